// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy frame generator and the matrix driver:
// game states, bird placement, LFSR seed/taps and the 8x8 grid type.
package flappy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam int         BIRD_COL       = 1;
  localparam logic [2:0] BIRD_START_ROW = 3'd3;
  localparam logic [7:0] LFSR_SEED      = 8'hA5;
  // Feedback taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
  localparam logic [7:0] LFSR_TAPS      = 8'hB8;

  // Element r = row r (row 0 at top), bit c = column c
  typedef logic [7:0][7:0] grid_t;

  // One Fibonacci step: shift left, feedback is the parity of the tapped bits
  function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

  // Grid with a single bit set at the bird position
  function automatic grid_t bird_grid(input logic [2:0] row);
    grid_t g;
    g = '0;
    g[row][BIRD_COL] = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; the low three bits pick pipe gap positions.
module lfsr8
  import flappy_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic [2:0] rnd_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Next LFSR value; a non-zero seed keeps the sequence out of the all-zero lock-up
  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
  end

  // Advance every clock regardless of game state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign rnd_o = lfsr_q[2:0];

endmodule

// File: rtl/flappy_frame_gen.sv
// Flappy-bird frame generator: keeps the bird position, scrolls the pipe
// columns, detects collisions and presents both layers as registered 8x8 grids.
module flappy_frame_gen
  import flappy_pkg::*;
#(
  parameter int GAP_H        = 3,
  parameter int PIPE_SPACING = 4,
  parameter int FALL_TICKS   = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            tick,
  input  logic            flap,
  input  logic            start,
  output logic [7:0][7:0] red_array,
  output logic [7:0][7:0] green_array,
  output logic            game_over,
  output logic [7:0]      score
);

  localparam logic [3:0] FALL_LIM    = 4'(FALL_TICKS);
  localparam logic [3:0] SPC_LAST    = 4'(PIPE_SPACING - 1);
  localparam logic [3:0] GAP_TOP_MAX = 4'(8 - GAP_H);
  localparam logic [3:0] GAP_LEN     = 4'(GAP_H);

  state_e     state_q;
  logic [2:0] row_q;
  logic [3:0] fall_q;
  logic [3:0] spc_q;
  logic       pend_q;
  grid_t      green_q;
  grid_t      red_q;
  logic [7:0] score_q;
  logic       over_q;

  logic [2:0] rnd_s;
  logic       flap_now_s;
  logic [2:0] row_d;
  logic [3:0] fall_d;
  logic       floor_s;
  logic [3:0] gap_top_s;
  logic [7:0] pipe_col_s;
  logic       spawn_s;
  grid_t      green_d;
  logic       passed_s;
  logic       coll_s;
  logic [7:0] score_d;
  logic [3:0] spc_d;

  lfsr8 u_lfsr (
    .clk_i  (clock),
    .rst_ni (reset),
    .rnd_o  (rnd_s)
  );

  // Bird motion for a tick: a pending or coincident flap lifts, otherwise gravity
  always_comb begin
    flap_now_s = pend_q | flap;
    row_d      = row_q;
    fall_d     = fall_q;
    floor_s    = 1'b0;
    if (flap_now_s) begin
      fall_d = 4'd0;
      if (row_q == 3'd0) begin
        row_d = 3'd0;
      end else begin
        row_d = row_q - 3'd1;
      end
    end else if ((fall_q + 4'd1) == FALL_LIM) begin
      fall_d = 4'd0;
      if (row_q == 3'd7) begin
        floor_s = 1'b1;
      end else begin
        row_d = row_q + 3'd1;
      end
    end else begin
      fall_d = fall_q + 4'd1;
    end
  end

  // Pipe scroll, new column at the right edge, passing and collision detection
  always_comb begin
    if ({1'b0, rnd_s} > GAP_TOP_MAX) begin
      gap_top_s = GAP_TOP_MAX;
    end else begin
      gap_top_s = {1'b0, rnd_s};
    end
    spawn_s  = (spc_q == 4'd0);
    passed_s = 1'b0;
    for (int r = 0; r < 8; r++) begin
      pipe_col_s[r] = !((4'(r) >= gap_top_s) && (4'(r) < (gap_top_s + GAP_LEN)));
      green_d[r]    = {spawn_s & pipe_col_s[r], green_q[r][7:1]};
      passed_s      = passed_s | green_q[r][BIRD_COL];
    end
    coll_s = green_d[row_d][BIRD_COL];
    if (passed_s && !coll_s && (score_q != 8'hFF)) begin
      score_d = score_q + 8'd1;
    end else begin
      score_d = score_q;
    end
    if (spc_q == SPC_LAST) begin
      spc_d = 4'd0;
    end else begin
      spc_d = spc_q + 4'd1;
    end
  end

  // Game FSM with all visible state held in registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      row_q   <= BIRD_START_ROW;
      fall_q  <= 4'd0;
      spc_q   <= 4'd0;
      pend_q  <= 1'b0;
      green_q <= '0;
      red_q   <= bird_grid(BIRD_START_ROW);
      score_q <= 8'd0;
      over_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_PLAY;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_PLAY: begin
          if (tick) begin
            row_q   <= row_d;
            fall_q  <= fall_d;
            pend_q  <= 1'b0;
            spc_q   <= spc_d;
            green_q <= green_d;
            red_q   <= bird_grid(row_d);
            score_q <= score_d;
            if (coll_s || floor_s) begin
              state_q <= ST_OVER;
              over_q  <= 1'b1;
            end else begin
              state_q <= ST_PLAY;
            end
          end else if (flap) begin
            pend_q <= 1'b1;
          end else begin
            pend_q <= pend_q;
          end
        end
        ST_OVER: begin
          if (start) begin
            state_q <= ST_IDLE;
            row_q   <= BIRD_START_ROW;
            fall_q  <= 4'd0;
            spc_q   <= 4'd0;
            pend_q  <= 1'b0;
            green_q <= '0;
            red_q   <= bird_grid(BIRD_START_ROW);
            score_q <= 8'd0;
            over_q  <= 1'b0;
          end else begin
            state_q <= ST_OVER;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          row_q   <= BIRD_START_ROW;
          fall_q  <= 4'd0;
          spc_q   <= 4'd0;
          pend_q  <= 1'b0;
          green_q <= '0;
          red_q   <= bird_grid(BIRD_START_ROW);
          score_q <= 8'd0;
          over_q  <= 1'b0;
        end
      endcase
    end
  end

  assign red_array   = red_q;
  assign green_array = green_q;
  assign game_over   = over_q;
  assign score       = score_q;

endmodule
